// File: rtl/thread_scheduler_pkg.sv
// Shared multithreading definitions: thread count, thread-ID width, per-thread
// state encoding and the per-thread event resolution used by the scheduler.
package thread_scheduler_pkg;

  localparam int MT_NUM_THREADS  = 8;
  localparam int MT_BITS_THREADS = $clog2(MT_NUM_THREADS);

  typedef enum logic [1:0] {
    TH_OFF  = 2'd0,
    TH_RUN  = 2'd1,
    TH_WAIT = 2'd2
  } thread_state_e;

  // Only the highest-priority event aimed at a thread is considered
  // (halt > wait > done > start); the rest are dropped. That event takes
  // effect only when it matches the thread's current state.
  function automatic thread_state_e next_thread_state(
    input thread_state_e cur,
    input logic          halt_e,
    input logic          wait_e,
    input logic          done_e,
    input logic          start_e
  );
    thread_state_e nxt;
    nxt = cur;
    if (halt_e) begin
      if (cur != TH_OFF) nxt = TH_OFF;
      else               nxt = cur;
    end else if (wait_e) begin
      if (cur == TH_RUN) nxt = TH_WAIT;
      else               nxt = cur;
    end else if (done_e) begin
      if (cur == TH_WAIT) nxt = TH_RUN;
      else                nxt = cur;
    end else if (start_e) begin
      if (cur == TH_OFF) nxt = TH_RUN;
      else               nxt = cur;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/thread_scheduler_rr_picker.sv
// Combinational circular picker: finds the first requesting index after
// start_idx, wrapping modulo NUM_THREADS and ending at start_idx itself.
module rr_picker
  import thread_scheduler_pkg::*;
#(
  parameter int NUM_THREADS  = MT_NUM_THREADS,
  parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0]  req_mask,
  input  logic [BITS_THREADS-1:0] start_idx,
  output logic [BITS_THREADS-1:0] grant_idx,
  output logic                    grant_valid
);

  // One extra bit so start_idx + offset never overflows before wrapping.
  localparam logic [BITS_THREADS:0] NUM_W = (BITS_THREADS + 1)'(NUM_THREADS);

  logic [BITS_THREADS:0]   sum_s;
  logic [BITS_THREADS-1:0] idx_s;

  // Walk offsets 1..NUM_THREADS from start_idx and keep the first hit.
  always_comb begin
    grant_idx   = start_idx;
    grant_valid = 1'b0;
    sum_s       = '0;
    idx_s       = '0;
    for (int off = 1; off <= NUM_THREADS; off++) begin
      sum_s = {1'b0, start_idx} + (BITS_THREADS + 1)'(off);
      if (sum_s >= NUM_W) sum_s = sum_s - NUM_W;
      else                sum_s = sum_s;
      idx_s = sum_s[BITS_THREADS-1:0];
      if (!grant_valid && req_mask[idx_s]) begin
        grant_idx   = idx_s;
        grant_valid = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Barrel-pipeline thread scheduler: tracks OFF/RUN/WAIT per thread and picks
// the next RUN thread for fetch in round-robin order each unstalled cycle.
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int NUM_THREADS  = MT_NUM_THREADS,
  parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_f,
  input  logic                    start_v,
  input  logic [BITS_THREADS-1:0] start_tid,
  input  logic                    halt_v,
  input  logic [BITS_THREADS-1:0] halt_tid,
  input  logic                    wait_v,
  input  logic [BITS_THREADS-1:0] wait_tid,
  input  logic                    done_v,
  input  logic [BITS_THREADS-1:0] done_tid,
  output logic [BITS_THREADS-1:0] tid_f,
  output logic                    tid_valid_f,
  output logic [NUM_THREADS-1:0]  run_mask,
  output logic                    all_off
);

  thread_state_e state_q [NUM_THREADS];
  thread_state_e state_d [NUM_THREADS];

  logic [BITS_THREADS-1:0] tid_f_q, tid_f_d;
  logic                    tid_valid_q, tid_valid_d;

  logic [BITS_THREADS-1:0] grant_idx_s;
  logic                    grant_valid_s;

  // Per-thread event decode; out-of-range tids match no thread and vanish.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      state_d[i] = next_thread_state(
        state_q[i],
        halt_v  && (halt_tid  == BITS_THREADS'(i)),
        wait_v  && (wait_tid  == BITS_THREADS'(i)),
        done_v  && (done_tid  == BITS_THREADS'(i)),
        start_v && (start_tid == BITS_THREADS'(i))
      );
    end
  end

  // Status views derived straight from the state registers.
  always_comb begin
    run_mask = '0;
    all_off  = 1'b1;
    for (int i = 0; i < NUM_THREADS; i++) begin
      run_mask[i] = (state_q[i] == TH_RUN);
      if (state_q[i] != TH_OFF) all_off = 1'b0;
      else                      all_off = all_off;
    end
  end

  // Search uses pre-edge states, so a state change is seen one cycle later.
  rr_picker #(
    .NUM_THREADS  (NUM_THREADS),
    .BITS_THREADS (BITS_THREADS)
  ) u_rr_picker (
    .req_mask    (run_mask),
    .start_idx   (tid_f_q),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Issue slot update: hold on stall, bubble (holding tid) when nothing runs.
  always_comb begin
    tid_f_d     = tid_f_q;
    tid_valid_d = tid_valid_q;
    if (!stall_f) begin
      if (grant_valid_s) begin
        tid_f_d     = grant_idx_s;
        tid_valid_d = 1'b1;
      end else begin
        tid_f_d     = tid_f_q;
        tid_valid_d = 1'b0;
      end
    end else begin
      tid_f_d     = tid_f_q;
      tid_valid_d = tid_valid_q;
    end
  end

  // State registers; reset overrides events and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        state_q[i] <= (i == 0) ? TH_RUN : TH_OFF;
      end
      tid_f_q     <= '0;
      tid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tid_f_q     <= tid_f_d;
      tid_valid_q <= tid_valid_d;
    end
  end

  assign tid_f       = tid_f_q;
  assign tid_valid_f = tid_valid_q;

endmodule

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 8, meaning the number of hardware threads in the barrel pipeline.
REQ-002 SHALL have parameter BITS_THREADS, default $clog2(NUM_THREADS), meaning the thread-ID width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall_f  in  1  fetch stall; holds the issue slot.
REQ-006 SHALL have port start_v / start_tid  in  1 / BITS_THREADS  request to launch thread start_tid.
REQ-007 SHALL have port halt_v / halt_tid  in  1 / BITS_THREADS  thread halt_tid retired ecall/halt.
REQ-008 SHALL have port wait_v / wait_tid  in  1 / BITS_THREADS  thread wait_tid blocked on a memory miss.
REQ-009 SHALL have port done_v / done_tid  in  1 / BITS_THREADS  memory miss of thread done_tid resolved.
REQ-010 SHALL have port tid_f  out  BITS_THREADS  thread ID issued to fetch/PC selection this cycle.
REQ-011 SHALL have port tid_valid_f  out  1  tid_f is a runnable thread; low = fetch bubble.
REQ-012 SHALL have port run_mask  out  NUM_THREADS  bit i high when thread i is in RUN.
REQ-013 SHALL have port all_off  out  1  every thread is in OFF.

Function
REQ-014 SHALL keep per-thread 2-bit state: OFF, RUN, WAIT.
REQ-015 SHALL apply these transitions on each edge: start_v moves OFF->RUN; wait_v moves RUN->WAIT; done_v moves WAIT->RUN; halt_v moves RUN or WAIT->OFF.
REQ-016 SHALL ignore events that do not match the current state: start on RUN/WAIT, done on RUN/OFF, wait on WAIT/OFF, halt on OFF.
REQ-017 SHALL resolve multiple events to the same tid in one cycle by priority halt > wait > done > start; lower-priority events to that tid are dropped.
REQ-018 SHALL apply events to different tids in the same cycle independently and together.
REQ-019 SHALL, on each edge with stall_f=0, choose the issue thread from the pre-edge states.
REQ-020 SHALL make that choice by circular search for the first RUN thread starting at tid_f+1 (mod NUM_THREADS) and ending at tid_f inclusive.
REQ-021 SHALL, when a RUN thread is found, register tid_f <= that thread and tid_valid_f <= 1.
REQ-022 SHALL, when no RUN thread is found, register tid_valid_f <= 0 and hold tid_f.
REQ-023 SHALL hold tid_f and tid_valid_f unchanged on an edge with stall_f=1, while thread-state events are still applied.
REQ-024 SHALL make a state change visible to issue selection one cycle after the event edge, so a thread entering WAIT may be issued at most once more.
REQ-025 SHALL produce run_mask and all_off combinationally from the state registers.
REQ-026 SHALL wrap the search index modulo NUM_THREADS and SHALL support non-power-of-two NUM_THREADS; tid values >= NUM_THREADS on event ports are ignored.
REQ-027 SHALL give a single RUN thread every issue slot (back-to-back issue).

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set thread 0 to RUN and threads 1..NUM_THREADS-1 to OFF.
REQ-029 SHALL, on reset, set tid_f=0 and tid_valid_f=0, giving run_mask=1 and all_off=0.
REQ-030 SHALL give rst priority over all events and over stall_f, including mid-operation.
REQ-031 SHALL issue thread 0 on the first non-stalled edge after reset deasserts.

Structure
REQ-032 SHALL take NUM_THREADS, BITS_THREADS and the OFF/RUN/WAIT state encodings from the shared multithreading package used by the per-thread PC and register file.
REQ-033 SHALL place the circular search in one sub-module, rr_picker (inputs: request mask, start index; outputs: grant index, grant valid), with purely combinational logic.
REQ-034 SHALL keep all other state in thread_scheduler, with no latches and no asynchronous logic.

Verification
REQ-035 SHALL cover: reset, then 4 idle cycles -> tid_f 0,0,0,0 and tid_valid_f=1 from the first edge after reset.
REQ-036 SHALL cover: start_v for tids 1..7 in one cycle each, then 16 cycles -> tid_f sequence 0,1,..,7,0,1,.. with no gaps.
REQ-037 SHALL cover: threads 0-3 RUN, wait_v tid 2 -> issue 0,1,3,0,1,3; done_v tid 2 -> tid 2 reappears in the next rotation.
REQ-038 SHALL cover: halt_v and start_v both on tid 5 (RUN) in one cycle -> tid 5 OFF and never issued; done_v on OFF tid 6 -> ignored.
REQ-039 SHALL cover: stall_f=1 for 3 cycles while tid_f=3 and tid 4 goes to WAIT -> tid_f holds 3; after release the next tid is 5.
REQ-040 SHALL cover: halt all threads -> tid_valid_f=0 and all_off=1; rst mid-rotation with tid_f=6 -> next cycle tid_f=0, only thread 0 RUN.
